ps2_tx: RTL and testbench
=========================

# ps2_tx

Host-to-device PS/2 transmitter: sends one command byte (LED set, typematic rate, reset, etc.) from the CPU to the keyboard over the same open-drain PS/2 clock/data pair that the keyboard receive path listens on. Runs entirely in the system `clk` domain, oversampling the device-generated PS/2 clock. It drives the lines only through active-low output enables, and reports completion and acknowledge status back to the bus interface.

## Interface
Parameters:
- `INHIBIT_CYCLES`, 5000: `clk` cycles the clock line is held low before the start bit (100 µs at 50 MHz).
- `TIMEOUT_CYCLES`, 1_000_000: cycles allowed from clock release to bus idle (20 ms at 50 MHz).

Ports:
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-high.
- `ps2_clk` in 1: raw PS/2 clock line readback; asynchronous.
- `ps2_data` in 1: raw PS/2 data line readback; asynchronous.
- `ps2_clk_oe` out 1: 1 = pull clock line low, 0 = release.
- `ps2_data_oe` out 1: 1 = pull data line low, 0 = release.
- `wen` in 1: write strobe; accepted only when `busy`=0.
- `wdata` in 8: command byte, captured on accepted `wen`.
- `busy` out 1: transfer in progress; receive path ignores clocks while set.
- `done` out 1: one-cycle pulse at end of transfer (success or failure).
- `err` out 1: valid with `done`; holds until next accepted `wen`.

## Operation
- Inputs pass through 2-flop synchronizers (reset value 1). Falling edge = previous synced 1, current 0.
- States: IDLE, INHIBIT, START, SHIFT, ACK, WAIT_IDLE.
- IDLE: both OEs 0, `busy`=0.
  - On `wen`: latch `{1'b1, ~^wdata, wdata}` (stop, odd parity, data LSB first).
  - Clear `err`, clear edge count, go INHIBIT.
- INHIBIT: `ps2_clk_oe`=1 for exactly INHIBIT_CYCLES cycles, then go START.
- START: one cycle with `ps2_clk_oe`=1 and `ps2_data_oe`=1 (start bit 0). Then go SHIFT and load the timeout counter.
- SHIFT: `ps2_clk_oe`=0. On each device falling edge n:
  - n = 1..8: set `ps2_data_oe` = ~data[n-1].
  - n = 9: set `ps2_data_oe` = ~parity.
  - n = 10: set `ps2_data_oe` = 0 (stop, line released) and go ACK.
- ACK: on the next falling edge (11th), sample synced data. 0 = acknowledged; 1 sets `err`. Go WAIT_IDLE.
- WAIT_IDLE: wait until synced clock and data are both 1, then pulse `done` and go IDLE.
- Timeout: counts every cycle in SHIFT, ACK and WAIT_IDLE. On reaching TIMEOUT_CYCLES:
  - release both OEs, set `err`, pulse `done`, go IDLE.
- `wen` while `busy` is ignored; there is no queueing.
- `wen` on the same cycle `done` pulses is ignored, because `busy` is still 1.
- Parity is odd over 8 data bits: parity bit = 1 when the data popcount is even.

## Timing
- Reset values: `ps2_clk_oe`=0, `ps2_data_oe`=0, `busy`=0, `done`=0, `err`=0, state IDLE, synchronizers 1.
- `rst` mid-transfer releases both lines asynchronously, in the same cycle, and abandons the byte; no `done` is produced.
- `busy` rises the cycle after an accepted `wen`; `ps2_clk_oe` rises on the same edge.
- The clock line is low for INHIBIT_CYCLES+1 cycles total (INHIBIT plus START).
- Edge-to-response latency: a device falling edge updates `ps2_data_oe` 3 `clk` cycles later (2 sync + 1 register). This is far inside the PS/2 half-period (≥30 µs).
- `done` is high for exactly one cycle, and `busy` falls on the same edge. `err` is registered alongside `done`.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Package `ps2_pkg`: state enum `ps2_tx_state_t`, default INHIBIT/TIMEOUT constants, `PS2_FRAME_BITS`=11. The package is shared with future receive-side rework.
- Sub-module `ps2_line_sync`: 2-flop synchronizer plus falling-edge detect for one line. Instantiated twice (clock edge output used, data level output used).
- Counter widths use `$clog2` of their parameter.

## Test plan
The bench uses INHIBIT_CYCLES=20 and TIMEOUT_CYCLES=2000, with a device model clocking at a 40-cycle period.
- Reset: assert `rst` → all outputs 0. Release; hold 10 cycles → no activity.
- `wen`, `wdata`=0xED:
  - `ps2_clk_oe` high 21 cycles.
  - Device samples on rising edges: 0,1,0,1,1,0,1,1,1, parity 1, stop 1.
  - Device drives ack 0 → `done` pulse, `err`=0.
- Parity corners: 0x00 → parity 1; 0xFF → parity 1; 0x01 → parity 0. Each completes with `err`=0.
- No ack: device leaves data high on the 11th edge → `done` with `err`=1, then IDLE.
- Device never clocks after START → `done` with `err`=1 exactly 2000 cycles after SHIFT entry; both OEs 0.
- Second `wen` (0x55) mid-SHIFT ignored: frame still carries 0xED. Then `rst` at edge 5 → both OEs 0 asynchronously, `busy`=0, no `done`.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, default timing constants, frame size.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_START,
    ST_SHIFT,
    ST_ACK,
    ST_WAIT_IDLE
  } ps2_tx_state_t;

  localparam int PS2_INHIBIT_CYCLES_DEF = 5000;
  localparam int PS2_TIMEOUT_CYCLES_DEF = 1_000_000;
  localparam int PS2_FRAME_BITS         = 11;

  // Counter width for a terminal count of n, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for one PS/2 line plus falling-edge detect on the synced value.
// Level is 2 cycles behind the pin; the fall strobe is a one-cycle pulse after that.
module ps2_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_line,
  output logic o_level,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_meta <= i_line;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_level = r_sync;
  assign o_fall  = r_prev & ~r_sync;

endmodule

// File: rtl/ps2_tx.sv
// Host-to-device PS/2 byte transmitter driving open-drain lines via output enables.
// One byte per wen while idle (no queueing); done/err report the outcome; all outputs registered.
module ps2_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = PS2_INHIBIT_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  input  logic       wen,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int IW = cnt_width(INHIBIT_CYCLES);
  localparam int TW = cnt_width(TIMEOUT_CYCLES);
  localparam int EW = $clog2(PS2_FRAME_BITS);
  localparam int FW = PS2_FRAME_BITS - 1;
  localparam logic [IW-1:0] INH_LAST  = IW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [EW-1:0] EDGE_LAST = EW'(PS2_FRAME_BITS - 2);

  logic w_clk_lvl, w_clk_fall, w_data_lvl, w_unused_data_fall;

  ps2_line_sync u_clk_sync (
    .clk     (clk),
    .rst     (rst),
    .i_line  (ps2_clk),
    .o_level (w_clk_lvl),
    .o_fall  (w_clk_fall)
  );

  ps2_line_sync u_data_sync (
    .clk     (clk),
    .rst     (rst),
    .i_line  (ps2_data),
    .o_level (w_data_lvl),
    .o_fall  (w_unused_data_fall)
  );

  ps2_tx_state_t r_state, w_state_n;
  logic [FW-1:0] r_frame, w_frame_n;
  logic [EW-1:0] r_edge_cnt, w_edge_n;
  logic [IW-1:0] r_inh_cnt, w_inh_n;
  logic [TW-1:0] r_to_cnt, w_to_n;
  logic          r_clk_oe, r_data_oe, r_busy, r_done, r_err;
  logic          w_clk_oe_n, w_data_oe_n, w_busy_n, w_done_n, w_err_n;
  logic          w_timed, w_timeout;

  // Once the device owns the clock, every state is bounded by one shared timeout.
  assign w_timed   = (r_state == ST_SHIFT) || (r_state == ST_ACK) || (r_state == ST_WAIT_IDLE);
  assign w_timeout = w_timed && (r_to_cnt == TO_LAST);

  always_comb begin
    w_state_n   = r_state;
    w_frame_n   = r_frame;
    w_edge_n    = r_edge_cnt;
    w_inh_n     = r_inh_cnt;
    w_to_n      = r_to_cnt;
    w_clk_oe_n  = r_clk_oe;
    w_data_oe_n = r_data_oe;
    w_busy_n    = r_busy;
    w_done_n    = 1'b0;
    w_err_n     = r_err;
    if (w_timeout) begin
      w_clk_oe_n  = 1'b0;
      w_data_oe_n = 1'b0;
      w_err_n     = 1'b1;
      w_done_n    = 1'b1;
      w_busy_n    = 1'b0;
      w_state_n   = ST_IDLE;
    end else begin
      if (w_timed) w_to_n = r_to_cnt + 1'b1;
      unique case (r_state)
        ST_IDLE: begin
          w_clk_oe_n  = 1'b0;
          w_data_oe_n = 1'b0;
          w_busy_n    = 1'b0;
          if (wen) begin
            w_frame_n  = {1'b1, ~^wdata, wdata};
            w_err_n    = 1'b0;
            w_edge_n   = '0;
            w_inh_n    = '0;
            w_clk_oe_n = 1'b1;
            w_busy_n   = 1'b1;
            w_state_n  = ST_INHIBIT;
          end
        end
        ST_INHIBIT: begin
          if (r_inh_cnt == INH_LAST) begin
            w_data_oe_n = 1'b1;
            w_state_n   = ST_START;
          end else begin
            w_inh_n = r_inh_cnt + 1'b1;
          end
        end
        ST_START: begin
          w_clk_oe_n = 1'b0;
          w_to_n     = '0;
          w_state_n  = ST_SHIFT;
        end
        ST_SHIFT: begin
          // Frame shifts out LSB first; the stop bit (1) ends up releasing the line.
          if (w_clk_fall) begin
            w_data_oe_n = ~r_frame[0];
            w_frame_n   = {1'b0, r_frame[FW-1:1]};
            w_edge_n    = r_edge_cnt + 1'b1;
            if (r_edge_cnt == EDGE_LAST) w_state_n = ST_ACK;
          end
        end
        ST_ACK: begin
          if (w_clk_fall) begin
            w_err_n   = w_data_lvl;
            w_state_n = ST_WAIT_IDLE;
          end
        end
        ST_WAIT_IDLE: begin
          if (w_clk_lvl && w_data_lvl) begin
            w_done_n  = 1'b1;
            w_busy_n  = 1'b0;
            w_state_n = ST_IDLE;
          end
        end
        default: begin
          w_clk_oe_n  = 1'b0;
          w_data_oe_n = 1'b0;
          w_busy_n    = 1'b0;
          w_state_n   = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_frame    <= '0;
      r_edge_cnt <= '0;
      r_inh_cnt  <= '0;
      r_to_cnt   <= '0;
      r_clk_oe   <= 1'b0;
      r_data_oe  <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_frame    <= w_frame_n;
      r_edge_cnt <= w_edge_n;
      r_inh_cnt  <= w_inh_n;
      r_to_cnt   <= w_to_n;
      r_clk_oe   <= w_clk_oe_n;
      r_data_oe  <= w_data_oe_n;
      r_busy     <= w_busy_n;
      r_done     <= w_done_n;
      r_err      <= w_err_n;
    end
  end

  assign ps2_clk_oe  = r_clk_oe;
  assign ps2_data_oe = r_data_oe;
  assign busy        = r_busy;
  assign done        = r_done;
  assign err         = r_err;

endmodule

// File: tb/tb_ps2_tx.sv
// Bench for ps2_tx: open-drain line model, PS/2 device model, queue-based done/frame scoreboard.
module tb_ps2_tx;

  localparam int INH = 20;
  localparam int TO  = 2000;
  localparam int M_ACK = 0, M_NOACK = 1, M_SILENT = 2, M_ABORT = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wen = 1'b0;
  logic [7:0] wdata = 8'h00;
  logic       ps2_clk, ps2_data, ps2_clk_oe, ps2_data_oe, busy, done, err;
  logic       dev_clk_hi = 1'b1;
  logic       dev_data_lo = 1'b0;
  logic       abort_pt = 1'b0;
  int         dev_mode = M_ACK;

  assign ps2_clk  = dev_clk_hi & ~ps2_clk_oe;
  assign ps2_data = ~dev_data_lo & ~ps2_data_oe;

  always #5 clk = ~clk;

  ps2_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .wen         (wen),
    .wdata       (wdata),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  typedef struct {
    logic err;
    logic chk_lat;
    int   lat;
  } exp_done_t;

  exp_done_t   exp_done_q[$];
  logic [10:0] exp_frame_q[$];
  int checks = 0;
  int failures = 0;
  int n_done = 0;
  int n_exp = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: inhibit length, timeout latency and done/err against the expected queue.
  logic      prev_coe = 1'b0;
  int        coe_run = 0;
  int        shift_entry = 0;
  exp_done_t mon_e;
  always @(negedge clk) begin
    if (ps2_clk_oe) coe_run++;
    else if (prev_coe) begin
      shift_entry = cyc;
      chk("clk_low_len", coe_run, INH + 1);
      coe_run = 0;
    end
    prev_coe = ps2_clk_oe;
    if (!rst && done) begin
      n_done++;
      if (exp_done_q.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        mon_e = exp_done_q.pop_front();
        chk("done_err", err, mon_e.err);
        chk("done_oe_released", {ps2_clk_oe, ps2_data_oe}, 0);
        if (mon_e.chk_lat) chk("timeout_latency", cyc - shift_entry, mon_e.lat);
      end
    end
  end

  // Device model: 40-cycle clock, samples data 2 cycles after each rising edge.
  initial begin : device
    logic [10:0] got;
    forever begin
      @(posedge ps2_clk_oe);
      @(negedge ps2_clk_oe);
      if (dev_mode == M_SILENT) continue;
      got = '0;
      repeat (2) @(negedge clk);
      got[0] = ps2_data;
      for (int i = 1; i <= 10; i++) begin
        repeat (18) @(negedge clk);
        dev_clk_hi = 1'b0;
        if (dev_mode == M_ABORT && i == 5) begin
          abort_pt = 1'b1;
          repeat (40) @(negedge clk);
          dev_clk_hi = 1'b1;
          abort_pt = 1'b0;
          break;
        end
        repeat (20) @(negedge clk);
        dev_clk_hi = 1'b1;
        repeat (2) @(negedge clk);
        got[i] = ps2_data;
      end
      if (dev_mode == M_ABORT) continue;
      if (exp_frame_q.size() == 0) chk("unexpected_frame", 1, 0);
      else chk("frame_bits", got, exp_frame_q.pop_front());
      repeat (5) @(negedge clk);
      dev_data_lo = (dev_mode == M_ACK);
      repeat (13) @(negedge clk);
      dev_clk_hi = 1'b0;
      repeat (20) @(negedge clk);
      dev_clk_hi = 1'b1;
      repeat (5) @(negedge clk);
      dev_data_lo = 1'b0;
    end
  end

  // Frame bits in device sample order: {stop, parity, data[7:0], start}.
  task automatic start_tx(input logic [7:0] d, input logic par, input int mode, input logic exp_err);
    exp_done_t e;
    dev_mode = mode;
    if (mode == M_ACK || mode == M_NOACK) exp_frame_q.push_back({1'b1, par, d, 1'b0});
    if (mode != M_ABORT) begin
      e.err = exp_err;
      e.chk_lat = (mode == M_SILENT);
      e.lat = TO;
      exp_done_q.push_back(e);
      n_exp++;
    end
    @(negedge clk);
    wen = 1'b1;
    wdata = d;
    @(negedge clk);
    wen = 1'b0;
    chk("busy_rise", busy, 1);
    chk("clk_oe_rise", ps2_clk_oe, 1);
  endtask

  task automatic wait_done();
    for (int k = 0; k < 6000 && n_done < n_exp; k++) @(negedge clk);
    if (n_done < n_exp) chk("done_wait_expired", n_done, n_exp);
    repeat (20) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] d;
    logic       par;
    int         mode;
    logic       err;
  } vec_t;

  vec_t vecs[6] = '{
    '{8'hED, 1'b1, M_ACK,    1'b0},
    '{8'h00, 1'b1, M_ACK,    1'b0},
    '{8'hFF, 1'b1, M_ACK,    1'b0},
    '{8'h01, 1'b0, M_ACK,    1'b0},
    '{8'hED, 1'b1, M_NOACK,  1'b1},
    '{8'hA5, 1'b1, M_SILENT, 1'b1}
  };

  initial begin : stim
    repeat (3) @(negedge clk);
    chk("rst_clk_oe", ps2_clk_oe, 0);
    chk("rst_data_oe", ps2_data_oe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_quiet", {ps2_clk_oe, ps2_data_oe, busy, done, err}, 0);
    end

    foreach (vecs[i]) begin
      start_tx(vecs[i].d, vecs[i].par, vecs[i].mode, vecs[i].err);
      wait_done();
    end

    // A second write during SHIFT must not disturb the frame in flight.
    start_tx(8'hED, 1'b1, M_ACK, 1'b0);
    for (int k = 0; k < 100 && ps2_clk_oe; k++) @(negedge clk);
    repeat (60) @(negedge clk);
    wen = 1'b1;
    wdata = 8'h55;
    @(negedge clk);
    wen = 1'b0;
    wait_done();

    // Reset at the 5th device edge abandons the byte and releases both lines at once.
    start_tx(8'hED, 1'b1, M_ABORT, 1'b0);
    for (int k = 0; k < 2000 && !abort_pt; k++) @(negedge clk);
    chk("abort_point_reached", abort_pt, 1);
    repeat (5) @(negedge clk);
    chk("pre_abort_data_oe", ps2_data_oe, 1);
    #2 rst = 1'b1;
    #1;
    chk("abort_clk_oe", ps2_clk_oe, 0);
    chk("abort_data_oe", ps2_data_oe, 0);
    chk("abort_busy", busy, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    chk("done_count", n_done, n_exp);
    chk("frames_left", exp_frame_q.size(), 0);
    chk("dones_left", exp_done_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
